// File: rtl/uart_ctrl_pkg.sv
// +-----------------------------------------------------------------------+
// | uart_ctrl_pkg                                                         |
// | Shared APB state encoding, UART register map and counter width.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      ACCESS   = 2'd2,
      COMPLETE = 2'd3
   } apb_state_e;

   localparam logic [31:0] LCR_ADDR     = 32'd2000;
   localparam logic [31:0] MDR_ADDR     = 32'd2004;
   localparam logic [31:0] TX_FIFO_ADDR = 32'd2008;

   localparam int TMO_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +-----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Combinational round-robin pick: search starts just after last_gnt.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_gnt,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = int'(last_gnt) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            idx           = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_apb_arbiter.sv
// +-----------------------------------------------------------------------+
// | uart_apb_arbiter                                                      |
// | Round-robin sharing of the UART APB slave port among NUM_REQ masters. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_apb_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_wr,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic                    err,
   output logic [31:0]             rdata,
   output logic [31:0]             padd,
   output logic [31:0]             pdata,
   output logic                    psel,
   output logic                    pen,
   output logic                    pwr,
   input  logic [31:0]             prdata,
   input  logic                    pready
);

   localparam int IDX_W = $clog2(NUM_REQ);

   apb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [31:0]            padd_q, padd_d;
   logic [31:0]            pdata_q, pdata_d;
   logic                   pwr_q, pwr_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0]     arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;
   int                     sel;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req      (req),
      .last_gnt (last_gnt_q),
      .gnt      (arb_gnt),
      .idx      (arb_idx),
      .any      (arb_any)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      padd_d     = padd_q;
      pdata_d    = pdata_q;
      pwr_d      = pwr_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      sel        = int'(arb_idx);
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               owner_d = arb_idx;
               gnt_d   = arb_gnt;
               padd_d  = req_addr[sel*32 +: 32];
               pdata_d = req_wdata[sel*32 +: 32];
               pwr_d   = req_wr[arb_idx];
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            // pready wins over a timeout reached on the same edge
            if (pready) begin
               if (!pwr_q) begin
                  rdata_d = prdata;
               end
               err_d   = 1'b0;
               state_d = COMPLETE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TMO_CNT_W'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = COMPLETE;
               end
            end
         end
         COMPLETE: begin
            last_gnt_d = owner_q;
            gnt_d      = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         last_gnt_q <= IDX_W'(NUM_REQ - 1);
         gnt_q      <= '0;
         padd_q     <= '0;
         pdata_q    <= '0;
         pwr_q      <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         padd_q     <= padd_d;
         pdata_q    <= pdata_d;
         pwr_q      <= pwr_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Strobes decode from the state so an async reset drops them at once
   assign psel  = (state_q == SETUP) || (state_q == ACCESS);
   assign pen   = (state_q == ACCESS);
   assign done  = (state_q == COMPLETE) ? gnt_q : '0;
   assign gnt   = gnt_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign padd  = padd_q;
   assign pdata = pdata_q;
   assign pwr   = pwr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_uart_apb_arbiter                                                   |
// | Directed stimulus with a queue scoreboard checked on every done.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_uart_apb_arbiter;

   localparam int NUM_REQ = 2;
   localparam int TIMEOUT = 4;
   localparam logic [31:0] STALL_ADDR = 32'hDEAD_0000;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_wr;
   logic [NUM_REQ*32-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_wdata;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    done;
   logic                  err;
   logic [31:0]           rdata;
   logic [31:0]           padd;
   logic [31:0]           pdata;
   logic                  psel;
   logic                  pen;
   logic                  pwr;
   logic [31:0]           prdata;
   logic                  pready;

   uart_apb_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .padd      (padd),
      .pdata     (pdata),
      .psel      (psel),
      .pen       (pen),
      .pwr       (pwr),
      .prdata    (prdata),
      .pready    (pready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          w;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_done_cyc = -100;
   int   psel_n = 0, pen_n = 0, gnt_n = 0;
   bit   chk_gap = 1'b0;
   int   slave_wait = 0;
   int   acc = 0;
   logic [31:0] slave_rdata = '0;
   exp_t e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int idx, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd,
                       input bit er, input int w);
      exp_t x;
      x.idx = idx; x.wr = wr; x.addr = addr; x.wdata = wdata;
      x.rdata = rd; x.err = er; x.w = w;
      q.push_back(x);
   endtask

   // Requester model: raise req, optionally drop it in SETUP, wait for done
   task automatic do_req(input int i, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit drop_in_setup);
      bit got;
      req_addr[i*32 +: 32]  = addr;
      req_wdata[i*32 +: 32] = wdata;
      req_wr[i] = wr;
      req[i]    = 1'b1;
      if (drop_in_setup) begin
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (psel && !pen && gnt[i]) got = 1'b1;
         end
         chk("setup_seen", 32'(got), 32'd1);
         req[i] = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (done[i]) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      req[i] = 1'b0;
   endtask

   // UART slave: ready after slave_wait stalled ACCESS cycles, never for STALL_ADDR
   always @(negedge clk) begin
      if (psel && pen) begin
         acc = acc + 1;
         pready = (padd != STALL_ADDR) && (acc > slave_wait);
      end else begin
         acc = 0;
         pready = 1'b0;
      end
      prdata = slave_rdata;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         psel_n = 0; pen_n = 0; gnt_n = 0;
      end else begin
         if (psel) psel_n++;
         if (pen)  pen_n++;
         if (|gnt) begin
            gnt_n++;
            chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
         end
         if (psel && q.size() > 0) begin
            chk("padd", padd, q[0].addr);
            chk("pdata", pdata, q[0].wdata);
            chk("pwr", 32'(pwr), 32'(q[0].wr));
            chk("gnt_owner", 32'(gnt), 32'(1 << q[0].idx));
         end
         if (psel && !pen && chk_gap && (cyc - last_done_cyc) < 10) begin
            chk("idle_gap", 32'(cyc - last_done_cyc), 32'd2);
         end
         if (done != '0) begin
            last_done_cyc = cyc;
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = q.pop_front();
               chk("done", 32'(done), 32'(1 << e.idx));
               chk("err", 32'(err), 32'(e.err));
               chk("rdata", rdata, e.rdata);
               chk("psel_cycles", 32'(psel_n), 32'(2 + e.w));
               chk("pen_cycles", 32'(pen_n), 32'(1 + e.w));
               chk("gnt_cycles", 32'(gnt_n), 32'(3 + e.w));
            end
            psel_n = 0; pen_n = 0; gnt_n = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit got;
      rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; prdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_pen", 32'(pen), 32'd0);
      chk("rst_padd", padd, 32'd0);
      chk("rst_pdata", pdata, 32'd0);
      chk("rst_pwr", 32'(pwr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single write, then single read
      push(0, 1'b1, 32'd2000, 32'h18, 32'h0, 1'b0, 0);
      do_req(0, 1'b1, 32'd2000, 32'h18, 1'b0);
      slave_rdata = 32'hCBD3_FF7F;
      push(1, 1'b0, 32'd2008, 32'h0, 32'hCBD3_FF7F, 1'b0, 0);
      do_req(1, 1'b0, 32'd2008, 32'h0, 1'b0);

      // contention: order 0,1,0,1 with one idle cycle between transfers
      repeat (12) @(negedge clk);
      slave_rdata = 32'h0000_00A5;
      chk_gap = 1'b1;
      push(0, 1'b1, 32'd2004, 32'h11, 32'hCBD3_FF7F, 1'b0, 0);
      push(1, 1'b0, 32'd2008, 32'h0,  32'h0000_00A5, 1'b0, 0);
      push(0, 1'b1, 32'd2008, 32'h22, 32'h0000_00A5, 1'b0, 0);
      push(1, 1'b0, 32'd2008, 32'h0,  32'h0000_00A5, 1'b0, 0);
      fork
         begin
            do_req(0, 1'b1, 32'd2004, 32'h11, 1'b0);
            do_req(0, 1'b1, 32'd2008, 32'h22, 1'b0);
         end
         begin
            do_req(1, 1'b0, 32'd2008, 32'h0, 1'b0);
            do_req(1, 1'b0, 32'd2008, 32'h0, 1'b0);
         end
      join
      chk_gap = 1'b0;

      // timeout on requester 0, then requester 1 still served
      repeat (2) @(negedge clk);
      slave_rdata = 32'h5A5A_0001;
      push(0, 1'b0, STALL_ADDR, 32'h0, 32'h0000_00A5, 1'b1, TIMEOUT - 1);
      push(1, 1'b0, 32'd2008,   32'h0, 32'h5A5A_0001, 1'b0, 0);
      fork
         do_req(0, 1'b0, STALL_ADDR, 32'h0, 1'b0);
         do_req(1, 1'b0, 32'd2008, 32'h0, 1'b0);
      join

      // pready on the same edge the counter reaches TIMEOUT is a success
      slave_wait = TIMEOUT - 1;
      push(1, 1'b1, 32'd2004, 32'h77, 32'h5A5A_0001, 1'b0, TIMEOUT - 1);
      do_req(1, 1'b1, 32'd2004, 32'h77, 1'b0);

      // requester drops req in SETUP; transfer still completes
      slave_wait = 2;
      push(0, 1'b1, 32'd2008, 32'h33, 32'h5A5A_0001, 1'b0, 2);
      do_req(0, 1'b1, 32'd2008, 32'h33, 1'b1);

      // reset in the middle of ACCESS
      slave_wait = 0;
      req_addr[32 +: 32] = STALL_ADDR;
      req_wr[1] = 1'b0;
      req[1] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (psel && pen) got = 1'b1;
      end
      chk("access_seen", 32'(got), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(psel), 32'd0);
      chk("mid_rst_pen", 32'(pen), 32'd0);
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      req[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(0, 1'b1, 32'd2000, 32'h44, 32'h0, 1'b0, 0);
      push(1, 1'b1, 32'd2004, 32'h55, 32'h0, 1'b0, 0);
      fork
         do_req(0, 1'b1, 32'd2000, 32'h44, 1'b0);
         do_req(1, 1'b1, 32'd2004, 32'h55, 1'b0);
      join

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
